// File: rtl/aqalu_pkg.sv
// aqalu_pkg: shared definitions for the AQALU vector sequencer.
//   - bit offsets of the fields inside a 16-bit table entry
//   - vec_t: packed view of one table entry
//   - SKIP_OPCODE: an entry with this opcode is applied but never compared
//   - state_e: sequencer FSM states
package aqalu_pkg;

  localparam int A_LSB   = 14;
  localparam int B_LSB   = 12;
  localparam int OP_LSB  = 8;
  localparam int EXP_LSB = 0;

  localparam logic [3:0] SKIP_OPCODE = 4'hF;

  // Field order matches the offsets above: {A, B, opcode, expected}.
  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] op;
    logic [7:0] exp;
  } vec_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_GAP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/aqalu_sec_tick.sv
// aqalu_sec_tick: elapsed-seconds counter.
// A prescaler counts enabled cycles; each time it reaches TICK_DIV-1 it wraps
// and the 8-bit seconds counter advances (wrapping 255 -> 0).
// Ports:
//   i_clock   system clock, rising edge
//   i_reset   asynchronous active-high reset
//   i_clr     synchronous clear of prescaler and seconds (wins over i_en)
//   i_en      count this cycle
//   o_seconds elapsed seconds
module aqalu_sec_tick #(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_clr,
  input  logic       i_en,
  output logic [7:0] o_seconds
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRE_W-1:0] r_pre;
  logic [7:0]       r_sec;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_pre <= '0;
      r_sec <= '0;
    end else if (i_clr) begin
      r_pre <= '0;
      r_sec <= '0;
    end else if (i_en) begin
      if (r_pre == PRE_W'(TICK_DIV - 1)) begin
        r_pre <= '0;
        r_sec <= r_sec + 8'd1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  assign o_seconds = r_sec;

endmodule

// File: rtl/aqalu_vector_sequencer.sv
// aqalu_vector_sequencer: plays a table of {A, B, opcode, expected} vectors
// into the AQALU, samples alu_result ALU_LAT+1 edges after each vector is
// applied and keeps match/mismatch statistics plus elapsed seconds.
// Optional feature: define AQALU_SEQ_STOP_ON_FAIL_EN to end a run at the
// first mismatching sample; by default every requested vector runs.
// Ports:
//   i_clock, i_reset        clock (rising edge), async active-high reset
//   i_wr_en/addr/data       table write port (ignored while busy)
//   i_count                 vectors to run, sampled on an accepted start
//   i_start                 single-cycle run request
//   i_alu_result            ALU output under test
//   o_A, o_B, o_Opcode      vector applied to the ALU
//   o_busy, o_done, o_fail  run status
//   o_match_cnt, o_mismatch_cnt, o_last_fail_idx, o_seconds  statistics
module aqalu_vector_sequencer
  import aqalu_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int PTR_W    = 4,
  parameter int ALU_LAT  = 1,
  parameter int STEP_GAP = 0,
  parameter int TICK_DIV = 10_000_000
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_wr_en,
  input  logic [PTR_W-1:0] i_wr_addr,
  input  logic [15:0]      i_wr_data,
  input  logic [PTR_W:0]   i_count,
  input  logic             i_start,
  input  logic [7:0]       i_alu_result,
  output logic [1:0]       o_A,
  output logic [1:0]       o_B,
  output logic [3:0]       o_Opcode,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_fail,
  output logic [PTR_W:0]   o_match_cnt,
  output logic [PTR_W:0]   o_mismatch_cnt,
  output logic [PTR_W-1:0] o_last_fail_idx,
  output logic [7:0]       o_seconds
);

  localparam int WAIT_W   = (ALU_LAT  > 0) ? $clog2(ALU_LAT + 1) : 1;
  localparam int GAP_W    = (STEP_GAP > 1) ? $clog2(STEP_GAP)    : 1;
  localparam int GAP_LAST = (STEP_GAP > 0) ? STEP_GAP - 1        : 0;

  logic [15:0]       r_table [DEPTH];
  state_e            r_state, w_next;
  logic [PTR_W-1:0]  r_idx, r_last, r_lfi;
  logic [WAIT_W-1:0] r_wait;
  logic [GAP_W-1:0]  r_gap;
  logic [1:0]        r_a, r_b;
  logic [3:0]        r_op;
  logic [7:0]        r_exp;
  logic [PTR_W:0]    r_match, r_mis;
  logic              r_fail;

  logic              w_busy, w_accept, w_sample, w_skip, w_mis, w_stop;
  logic              w_load_next, w_load;
  logic [PTR_W:0]    w_cnt_m1;
  logic [PTR_W-1:0]  w_last, w_ld_idx;
  vec_t              w_ld_vec;

  assign w_busy   = (r_state == ST_WAIT) || (r_state == ST_GAP);
  assign w_accept = i_start && (i_count != '0) &&
                    ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_sample = (r_state == ST_WAIT) && (r_wait == WAIT_W'(ALU_LAT));
  assign w_skip   = (r_op == SKIP_OPCODE);
  assign w_mis    = w_sample && !w_skip && (i_alu_result != r_exp);

  // Index of the last vector to run; requests beyond the table are clamped.
  assign w_cnt_m1 = i_count - 1'b1;
  assign w_last   = (i_count > (PTR_W+1)'(DEPTH)) ? PTR_W'(DEPTH - 1)
                                                  : w_cnt_m1[PTR_W-1:0];

`ifdef AQALU_SEQ_STOP_ON_FAIL_EN
  assign w_stop = (r_idx == r_last) || w_mis;
`else
  assign w_stop = (r_idx == r_last);
`endif

  // One table read port serves both the first load and every following one.
  assign w_load   = w_accept || w_load_next;
  assign w_ld_idx = w_accept ? '0 : r_idx + 1'b1;
  assign w_ld_vec = vec_t'(r_table[w_ld_idx]);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_load_next = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: if (w_accept) w_next = ST_WAIT;
      ST_WAIT: begin
        if (w_sample) begin
          if (w_stop)             w_next = ST_DONE;
          else if (STEP_GAP == 0) w_load_next = 1'b1;
          else                    w_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_gap == GAP_W'(GAP_LAST)) begin
          w_next      = ST_WAIT;
          w_load_next = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Table has no reset; contents survive a reset.
  always_ff @(posedge i_clock) begin
    if (i_wr_en && !w_busy) r_table[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_idx   <= '0;
      r_last  <= '0;
      r_lfi   <= '0;
      r_wait  <= '0;
      r_gap   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_exp   <= '0;
      r_match <= '0;
      r_mis   <= '0;
      r_fail  <= 1'b0;
    end else begin
      if (w_load) begin
        r_idx  <= w_ld_idx;
        r_a    <= w_ld_vec.a;
        r_b    <= w_ld_vec.b;
        r_op   <= w_ld_vec.op;
        r_exp  <= w_ld_vec.exp;
        r_wait <= '0;
      end else if ((r_state == ST_WAIT) && !w_sample) begin
        r_wait <= r_wait + 1'b1;
      end

      if (r_state == ST_GAP) r_gap <= r_gap + 1'b1;
      else                   r_gap <= '0;

      if (w_accept) begin
        r_last  <= w_last;
        r_match <= '0;
        r_mis   <= '0;
        r_fail  <= 1'b0;
      end else if (w_sample && !w_skip) begin
        if (w_mis) begin
          r_mis  <= r_mis + 1'b1;
          r_fail <= 1'b1;
          r_lfi  <= r_idx;
        end else begin
          r_match <= r_match + 1'b1;
        end
      end
    end
  end

  aqalu_sec_tick #(.TICK_DIV(TICK_DIV)) u_sec_tick (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_clr     (w_accept),
    .i_en      (w_busy),
    .o_seconds (o_seconds)
  );

  assign o_A             = r_a;
  assign o_B             = r_b;
  assign o_Opcode        = r_op;
  assign o_busy          = w_busy;
  assign o_done          = (r_state == ST_DONE);
  assign o_fail          = r_fail;
  assign o_match_cnt     = r_match;
  assign o_mismatch_cnt  = r_mis;
  assign o_last_fail_idx = r_lfi;

endmodule

// File: tb/tb_aqalu_vector_sequencer.sv
// Bench for aqalu_vector_sequencer with a loopback ALU:
// alu_result = {A, B, Opcode} registered once (ALU_LAT=1), STEP_GAP=0, TICK_DIV=4.
module tb_aqalu_vector_sequencer;

  localparam int PTR_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic [PTR_W-1:0] wr_addr = '0;
  logic [15:0]      wr_data = '0;
  logic [PTR_W:0]   count = '0;
  logic             start = 1'b0;
  logic [7:0]       alu = '0;
  logic [1:0]       a, b;
  logic [3:0]       op;
  logic             busy, done, fail;
  logic [PTR_W:0]   match_cnt, mismatch_cnt;
  logic [PTR_W-1:0] lfi;
  logic [7:0]       seconds;

  int ntests = 0;
  int nfail  = 0;
  int cyc;

  always #5 clk = ~clk;

  always @(posedge clk) alu <= {a, b, op};

  aqalu_vector_sequencer #(
    .DEPTH(16), .PTR_W(PTR_W), .ALU_LAT(1), .STEP_GAP(0), .TICK_DIV(4)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_count(count), .i_start(start), .i_alu_result(alu),
    .o_A(a), .o_B(b), .o_Opcode(op), .o_busy(busy), .o_done(done), .o_fail(fail),
    .o_match_cnt(match_cnt), .o_mismatch_cnt(mismatch_cnt),
    .o_last_fail_idx(lfi), .o_seconds(seconds)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] vec(input logic [1:0] va, input logic [1:0] vb,
                                      input logic [3:0] vop, input logic [7:0] ve);
    return {va, vb, vop, ve};
  endfunction

  // Entry whose expected value is what the loopback ALU returns.
  function automatic logic [15:0] lb(input logic [1:0] va, input logic [1:0] vb,
                                     input logic [3:0] vop);
    return {va, vb, vop, va, vb, vop};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [PTR_W-1:0] ad, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = ad; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Start a run and return the number of cycles busy stayed high.
  task automatic run(input int n, output int c);
    count = (PTR_W+1)'(n); start = 1'b1;
    tick();
    start = 1'b0;
    c = 0;
    while (busy && c < 100) begin
      tick();
      c++;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ab"},   {a, b, op},     '0);
    check({tag, "_busy"}, busy,           '0);
    check({tag, "_done"}, done,           '0);
    check({tag, "_fail"}, fail,           '0);
    check({tag, "_cnt"},  {match_cnt, mismatch_cnt}, '0);
    check({tag, "_lfi"},  lfi,            '0);
    check({tag, "_sec"},  seconds,        '0);
  endtask

  initial begin
    repeat (2) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // Table: 0..2 good, 3 skip (expected would mismatch), 4..15 good.
    wr(4'd0, lb(2'd2, 2'd1, 4'd3));
    wr(4'd1, lb(2'd1, 2'd2, 4'd5));
    wr(4'd2, lb(2'd3, 2'd3, 4'hA));
    wr(4'd3, vec(2'd0, 2'd0, 4'hF, 8'h00));
    for (int i = 4; i < 16; i++) begin
      logic [3:0] iv;
      iv = 4'(i);
      wr(iv, lb(iv[3:2], iv[1:0], 4'(i % 7)));
    end
    check("entry0_exp", lb(2'd2, 2'd1, 4'd3), 16'h9393);

    // All-pass run of 3.
    run(3, cyc);
    check("pass_cycles", cyc, 6);
    check("pass_done", done, 1);
    check("pass_match", match_cnt, 3);
    check("pass_mis", mismatch_cnt, 0);
    check("pass_fail", fail, 0);
    check("pass_sec", seconds, 1);

    // Entry 1 with a wrong expected value.
    wr(4'd1, vec(2'd1, 2'd2, 4'd5, 8'h00));
    run(3, cyc);
`ifdef AQALU_SEQ_STOP_ON_FAIL_EN
    check("mis_cycles", cyc, 4);
    check("mis_match", match_cnt, 1);
`else
    check("mis_cycles", cyc, 6);
    check("mis_match", match_cnt, 2);
`endif
    check("mis_mis", mismatch_cnt, 1);
    check("mis_lfi", lfi, 1);
    check("mis_fail", fail, 1);
    repeat (2) tick();
    check("mis_done_hold", {done, fail, mismatch_cnt}, {1'b1, 1'b1, 5'd1});

    // Skip entry among 4.
    wr(4'd1, lb(2'd1, 2'd2, 4'd5));
    run(4, cyc);
    check("skip_cycles", cyc, 8);
    check("skip_total", match_cnt + mismatch_cnt, 3);
    check("skip_fail", fail, 0);

    // Seconds and clamping.
    run(5, cyc);
    check("c5_cycles", cyc, 10);
    check("c5_sec", seconds, 2);
    check("c5_match", match_cnt, 4);
    run(20, cyc);
    check("c20_cycles", cyc, 32);
    check("c20_sec", seconds, 8);
    check("c20_match", match_cnt, 15);
    check("c20_mis", mismatch_cnt, 0);

    // Reset in the middle of a run.
    count = 5'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check("v0_visible", {busy, a, b, op}, {1'b1, 2'd2, 2'd1, 4'd3});
    repeat (3) tick();
    check("pre_rst_match", match_cnt, 1);
    rst = 1'b1;
    #1;
    check_zero("midrst");
    tick();
    rst = 1'b0;
    tick();
    run(3, cyc);
    check("rerun_cycles", cyc, 6);
    check("rerun_match", match_cnt, 3);

    // start and wr_en while busy are ignored.
    count = 5'd3; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    tick(); cyc++;
    tick(); cyc++;
    start = 1'b1; count = 5'd5;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h0000;
    tick(); cyc++;
    start = 1'b0; wr_en = 1'b0;
    while (busy && cyc < 100) begin
      tick();
      cyc++;
    end
    check("busy_cycles", cyc, 6);
    check("busy_match", {match_cnt, mismatch_cnt}, {5'd3, 5'd0});
    run(1, cyc);
    check("tbl_kept", {match_cnt, mismatch_cnt, a, b, op}, {5'd1, 5'd0, 2'd2, 2'd1, 4'd3});

    // start with count == 0 from IDLE.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    count = 5'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("cnt0_idle", {busy, done}, 2'b00);
    tick();
    check("cnt0_still", {busy, done}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
